bcd_digit_serial_adder_ctrl: RTL

Sequencer that time-multiplexes one shared 4-bit binary adder across a multi-digit packed-BCD addition, one decimal digit per clock, least-significant digit first. It applies decimal correction to each digit and latches the final result. It sits between the operand source (switch/register front end) and the display path. Results appear only after all digits complete.

---
 rtl/bcd_digit_serial_adder_ctrl_if.sv | 26 ++
 rtl/bcd_digit_serial_adder_ctrl.sv | 113 +++++++++++
 2 files changed

// File: rtl/bcd_digit_serial_adder_ctrl_if.sv
// Operand/result bundle for the digit-serial BCD adder.
//   master: operand source (drives start, a, b, ci; observes results)
//   slave : adder sequencer (observes operands; drives busy, done, sum, cout, err)
interface bcd_digit_serial_adder_ctrl_if #(
  parameter int unsigned DIGITS = 2
);
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  ci;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   sum;
  logic                  cout;
  logic                  err;

  modport master (
    output start, a, b, ci,
    input  busy, done, sum, cout, err
  );

  modport slave (
    input  start, a, b, ci,
    output busy, done, sum, cout, err
  );
endinterface

// File: rtl/bcd_digit_serial_adder_ctrl.sv
// Digit-serial packed-BCD adder sequencer. One shared 4-bit adder processes
// one decimal digit per clock, least-significant digit first, with decimal
// correction; the full result is latched into sum/cout/err on entry to DONE.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset
//   bus   - slave side of bcd_digit_serial_adder_ctrl_if:
//           start/a/b/ci in; busy/done/sum/cout/err out
module bcd_digit_serial_adder_ctrl #(
  parameter int unsigned DIGITS = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  bcd_digit_serial_adder_ctrl_if.slave  bus
);

  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            state;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   op_a;
  logic [4*DIGITS-1:0]   op_b;
  logic                  carry;
  logic [4*DIGITS-1:0]   work;
  logic                  err_lat;
  logic [4*DIGITS-1:0]   sum_r;
  logic                  cout_r;
  logic                  err_r;

  logic                  in_err;
  logic [3:0]            dig_a;
  logic [3:0]            dig_b;
  logic [4:0]            raw;
  logic                  corr;
  logic [3:0]            digit;
  logic [4*DIGITS-1:0]   work_next;

  // Any non-BCD digit in the operands presented with start.
  always_comb begin
    in_err = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bus.a[4*i +: 4] > 4'd9 || bus.b[4*i +: 4] > 4'd9) in_err = 1'b1;
    end
  end

  // Single shared digit adder fed through the digit-select muxes.
  assign dig_a = op_a[{idx, 2'b00} +: 4];
  assign dig_b = op_b[{idx, 2'b00} +: 4];
  assign raw   = {1'b0, dig_a} + {1'b0, dig_b} + {4'b0000, carry};
  assign corr  = (raw > 5'd9);
  assign digit = corr ? (raw[3:0] + 4'd6) : raw[3:0];

  // Final-digit write is folded in here so the result copy sees it this cycle.
  always_comb begin
    work_next = work;
    work_next[{idx, 2'b00} +: 4] = digit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      idx     <= '0;
      op_a    <= '0;
      op_b    <= '0;
      carry   <= 1'b0;
      work    <= '0;
      err_lat <= 1'b0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            op_a    <= bus.a;
            op_b    <= bus.b;
            carry   <= bus.ci;
            idx     <= '0;
            work    <= '0;
            err_lat <= in_err;
            state   <= S_RUN;
          end else begin
            state   <= S_IDLE;
          end
        end
        S_RUN: begin
          work  <= work_next;
          carry <= corr;
          if (idx == IW'(DIGITS - 1)) begin
            sum_r  <= work_next;
            cout_r <= corr;
            err_r  <= err_lat;
            state  <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = (state == S_RUN);
  assign bus.done = (state == S_DONE);
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
  assign bus.err  = err_r;

endmodule
